axi4lite_mem_slave: RTL
=======================

// Module: axi4lite_mem_slave
// PURPOSE
//  AXI4-Lite memory-backed slave, the downstream consumer of axi4liteRandomMaster.
//  Accepts AW/W/AR independently, commits byte-strobed writes to a local word
//  array, returns B and R responses with the request ID echoed.
//  Used as the end-point in random-traffic soak benches and as a small FPGA scratchpad.
// PARAMETERS
//  ADDR_W      16  byte-address width
//  DATA_BYTEW  4   data bus width in bytes (power of 2)
//  ID_W        4   transaction ID width
//  DEPTH       64  number of data words (power of 2, DEPTH*DATA_BYTEW <= 2**ADDR_W)
// PORTS
//  i_clk          in   1              clock
//  i_rst_n        in   1              reset, synchronous, active-low
//  i_axi_AWID/AWADDR/AWPROT/AWVALID   in   ID_W/ADDR_W/3/1   write address
//  o_axi_AWREADY  out  1              write address ready
//  i_axi_WDATA/WSTRB/WVALID           in   DATA_BYTEW*8/DATA_BYTEW/1  write data
//  o_axi_WREADY   out  1              write data ready
//  o_axi_BID/BRESP/BVALID             out  ID_W/2/1          write response
//  i_axi_BREADY   in   1              write response ready
//  i_axi_ARID/ARADDR/ARPROT/ARVALID   in   ID_W/ADDR_W/3/1   read address
//  o_axi_ARREADY  out  1              read address ready
//  o_axi_RID/RDATA/RRESP/RVALID       out  ID_W/DATA_BYTEW*8/2/1  read data
//  i_axi_RREADY   in   1              read data ready
// BEHAVIOUR
//  Reset (i_rst_n==0 at posedge): all VALID/READY outputs 0 while low; memory,
//   hold regs, BID/RID/BRESP/RRESP/RDATA cleared to 0. Mid-operation reset drops
//   held AW/W, pending B and R; no partial write ever reaches memory.
//  Address decode: word = ADDR >> log2(DATA_BYTEW); in-range iff word < DEPTH.
//   Low byte-offset bits ignored. AWPROT/ARPROT ignored.
//  Write path: 1-entry hold reg each for AW {id,addr} and W {data,strb}.
//   AWREADY = !rst && !awHeld; WREADY = !rst && !wHeld (registered sources).
//   AW and W may arrive in any order, any gap; each held until its partner arrives.
//   Commit when awHeld && wHeld && (!BVALID || BREADY): in-range -> bytes with
//   WSTRB[i]=1 written, BRESP=OKAY(00); out-of-range -> no write, BRESP=DECERR(11).
//   Commit clears both holds and loads BVALID=1, BID=held id, on the same edge.
//   Latency: AW+W handshake at edge N -> commit at N+1 -> BVALID visible after N+1.
//   BVALID/BID/BRESP stable until BREADY; strobe 0000 is a legal no-op write (OKAY).
//  Read path: AR handshake = ARVALID && ARREADY; ARREADY = !rst && (!RVALID || RREADY).
//   On handshake: RVALID=1, RID=ARID, RDATA=mem[word] (0 if out-of-range),
//   RRESP=OKAY / DECERR, visible the cycle after handshake (latency 1).
//   RVALID && !RREADY: all R outputs held stable, ARREADY=0.
//   Back-to-back reads at full rate when RREADY held high.
//  Read/write same word, same edge: read returns pre-write data.
//  No ordering between write and read channels beyond the above.
// STRUCTURE
//  Package axi4lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11,
//   and a function wordIndex(addr) shared with other AXI4-Lite blocks.
//  One sub-module axi4lite_mem_array: DEPTH x DATA_BYTEW*8 array with per-byte
//   write enable, synchronous clear, one combinational read port; top holds FSM regs.
// TESTING
//  1 Reset low 5 cycles, then high -> all VALIDs 0; AWREADY=WREADY=ARREADY=1 first
//    cycle after release.
//  2 AW{id 3,0x0008}+W{0xDEADBEEF,F} same cycle, BREADY=1 -> BVALID 2 edges later,
//    BID=3 BRESP=00; AR{id 5,0x0008} -> next cycle RVALID RID=5 RDATA=0xDEADBEEF.
//  3 W{0x11223344,0101} 3 cycles before AW{0x0008} -> WREADY=0 until commit;
//    read 0x0008 -> 0xDE22BE44.
//  4 BREADY=0 for 10 cycles, issue 2 writes -> second held, AWREADY=WREADY=0, mem
//    unchanged until first B accepted; then B for second with its ID.
//  5 Write/read addr DEPTH*DATA_BYTEW (0x0100) -> BRESP=11, RRESP=11, RDATA=0, mem intact.
//  6 Reset asserted while BVALID=1 and RVALID=1 -> both 0 next cycle; read 0x0008 -> 0.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// AXI4-Lite response codes and the byte-address to word-index helper shared by
// the AXI4-Lite end-points.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // off_bits is log2 of the bus width in bytes; the byte-offset bits are dropped.
    function automatic logic [31:0] wordIndex(input logic [31:0] addr, input int unsigned off_bits);
        return addr >> off_bits;
    endfunction

endpackage

// File: rtl/axi4lite_mem_array.sv
// Word array with per-byte write enables, synchronous clear and one
// combinational read port.
module axi4lite_mem_array #(
    parameter int DEPTH      = 64,
    parameter int DATA_BYTEW = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [DATA_BYTEW-1:0]       i_we,
    input  logic [$clog2(DEPTH)-1:0]    i_waddr,
    input  logic [DATA_BYTEW*8-1:0]     i_wdata,
    input  logic [$clog2(DEPTH)-1:0]    i_raddr,
    output logic [DATA_BYTEW*8-1:0]     o_rdata
);

    logic [DATA_BYTEW*8-1:0] mem_q [DEPTH];
    logic [DATA_BYTEW*8-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < DATA_BYTEW; b++) begin
            if (i_we[b]) begin
                mem_d[i_waddr][b*8 +: 8] = i_wdata[b*8 +: 8];
            end
        end
    end

    // NOTE: the array must read back as zero after reset, so it is cleared like
    // any other register and therefore maps to flops, not block RAM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite memory-backed slave: one-entry AW and W holds feeding a byte-strobed
// word array, single-beat B and R responses carrying the request ID.
module axi4lite_mem_slave
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_BYTEW = 4,
    parameter int ID_W       = 4,
    parameter int DEPTH      = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [ID_W-1:0]          i_axi_AWID,
    input  logic [ADDR_W-1:0]        i_axi_AWADDR,
    input  logic [2:0]               i_axi_AWPROT,
    input  logic                     i_axi_AWVALID,
    output logic                     o_axi_AWREADY,
    input  logic [DATA_BYTEW*8-1:0]  i_axi_WDATA,
    input  logic [DATA_BYTEW-1:0]    i_axi_WSTRB,
    input  logic                     i_axi_WVALID,
    output logic                     o_axi_WREADY,
    output logic [ID_W-1:0]          o_axi_BID,
    output logic [1:0]               o_axi_BRESP,
    output logic                     o_axi_BVALID,
    input  logic                     i_axi_BREADY,
    input  logic [ID_W-1:0]          i_axi_ARID,
    input  logic [ADDR_W-1:0]        i_axi_ARADDR,
    input  logic [2:0]               i_axi_ARPROT,
    input  logic                     i_axi_ARVALID,
    output logic                     o_axi_ARREADY,
    output logic [ID_W-1:0]          o_axi_RID,
    output logic [DATA_BYTEW*8-1:0]  o_axi_RDATA,
    output logic [1:0]               o_axi_RRESP,
    output logic                     o_axi_RVALID,
    input  logic                     i_axi_RREADY
);

    localparam int DATA_W = DATA_BYTEW * 8;
    localparam int OFF_W  = $clog2(DATA_BYTEW);
    localparam int IDX_W  = $clog2(DEPTH);

    logic              aw_held_q, aw_held_d;
    logic [ID_W-1:0]   aw_id_q,   aw_id_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic              w_held_q,  w_held_d;
    logic [DATA_W-1:0] w_data_q,  w_data_d;
    logic [DATA_BYTEW-1:0] w_strb_q, w_strb_d;
    logic              b_valid_q, b_valid_d;
    logic [ID_W-1:0]   b_id_q,    b_id_d;
    resp_e             b_resp_q,  b_resp_d;
    logic              r_valid_q, r_valid_d;
    logic [ID_W-1:0]   r_id_q,    r_id_d;
    logic [DATA_W-1:0] r_data_q,  r_data_d;
    resp_e             r_resp_q,  r_resp_d;

    logic [31:0]          aw_word, ar_word;
    logic [IDX_W-1:0]     mem_waddr, mem_raddr;
    logic [DATA_W-1:0]    mem_rdata;
    logic [DATA_BYTEW-1:0] mem_we;
    logic aw_hit, ar_hit, aw_hs, w_hs, ar_hs, commit;
    logic unused_prot;

    assign unused_prot = ^{i_axi_AWPROT, i_axi_ARPROT};

    assign aw_word   = wordIndex(32'(aw_addr_q), OFF_W);
    assign ar_word   = wordIndex(32'(i_axi_ARADDR), OFF_W);
    assign aw_hit    = aw_word < 32'(DEPTH);
    assign ar_hit    = ar_word < 32'(DEPTH);
    assign mem_waddr = aw_word[IDX_W-1:0];
    assign mem_raddr = ar_word[IDX_W-1:0];

    assign o_axi_AWREADY = i_rst_n && !aw_held_q;
    assign o_axi_WREADY  = i_rst_n && !w_held_q;
    assign o_axi_ARREADY = i_rst_n && (!r_valid_q || i_axi_RREADY);

    assign aw_hs  = i_axi_AWVALID && o_axi_AWREADY;
    assign w_hs   = i_axi_WVALID  && o_axi_WREADY;
    assign ar_hs  = i_axi_ARVALID && o_axi_ARREADY;
    // A commit only retires once the previous B has been taken or is taken now.
    assign commit = aw_held_q && w_held_q && (!b_valid_q || i_axi_BREADY);
    assign mem_we = (commit && aw_hit) ? w_strb_q : '0;

    axi4lite_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_BYTEW (DATA_BYTEW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (mem_we),
        .i_waddr (mem_waddr),
        .i_wdata (w_data_q),
        .i_raddr (mem_raddr),
        .o_rdata (mem_rdata)
    );

    // NOTE: every _d starts from its _q so no branch leaves a value unassigned
    // and no latch is inferred.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_id_d   = aw_id_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_id_d   = i_axi_AWID;
            aw_addr_d = i_axi_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = i_axi_WDATA;
            w_strb_d = i_axi_WSTRB;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_id_d    = aw_id_q;
            b_resp_d  = aw_hit ? RESP_OKAY : RESP_DECERR;
        end else if (b_valid_q && i_axi_BREADY) begin
            b_valid_d = 1'b0;
        end
    end

    always_comb begin
        r_valid_d = r_valid_q;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;

        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_id_d    = i_axi_ARID;
            r_data_d  = ar_hit ? mem_rdata : '0;
            r_resp_d  = ar_hit ? RESP_OKAY : RESP_DECERR;
        end else if (r_valid_q && i_axi_RREADY) begin
            r_valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge values,
    // which is also what gives a same-edge read the pre-write data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            aw_held_q <= 1'b0;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= RESP_OKAY;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            aw_id_q   <= aw_id_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

    assign o_axi_BVALID = b_valid_q;
    assign o_axi_BID    = b_id_q;
    assign o_axi_BRESP  = b_resp_q;
    assign o_axi_RVALID = r_valid_q;
    assign o_axi_RID    = r_id_q;
    assign o_axi_RDATA  = r_data_q;
    assign o_axi_RRESP  = r_resp_q;

endmodule
